// File: rtl/fsm_input_conditioner_pkg.sv
// Shared types and constants for the step/direction input conditioner
// that feeds the 3-bit up/down sequence counter.
package fsm_input_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam state_e STATE_RST  = ST_IDLE;
    localparam logic   PULSE_RST  = 1'b0;
    localparam logic   UP_RST     = 1'b0;
    localparam logic   REPEAT_RST = 1'b0;
    localparam logic   LEVEL_RST  = 1'b0;

    // Width needed to hold values 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 32'd1) ? 32'd1 : $clog2(v);
    endfunction

    // One timer serves both HOLD and REPEAT, so it is sized for the longer interval.
    function automatic int unsigned timer_width(input int unsigned hold_cycles,
                                                input int unsigned repeat_cycles);
        return clog2_min1((hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles);
    endfunction

endpackage

// File: rtl/fsm_input_conditioner_if.sv
// Raw button/switch inputs and conditioned outputs of the input conditioner.
interface fsm_input_conditioner_if;

    logic btn_step_raw;
    logic sw_up_raw;
    logic step_pulse;
    logic up;
    logic repeat_active;

    modport master (
        output btn_step_raw,
        output sw_up_raw,
        input  step_pulse,
        input  up,
        input  repeat_active
    );

    modport slave (
        input  btn_step_raw,
        input  sw_up_raw,
        output step_pulse,
        output up,
        output repeat_active
    );

endinterface

// File: rtl/fsm_input_conditioner_debounce_filter.sv
// Synchroniser chain followed by a stable-count debouncer for one raw input.
import fsm_input_conditioner_pkg::*;

module debounce_filter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);

    localparam int unsigned        CNT_W   = clog2_min1(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_s;
    logic                   level_q;
    logic                   level_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    assign synced_s = sync_q[SYNC_STAGES-1];
    assign level_o  = level_q;

    // Synchroniser shift chain; only its last stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    // Level flips only after the synced value has disagreed for DEBOUNCE_CYCLES+1 checks.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Debounce counter and filtered level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= LEVEL_RST;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/fsm_input_conditioner.sv
// Front end of the up/down counter: debounced step button becomes a one-cycle
// step pulse with hold-to-auto-repeat; debounced switch becomes the direction level.
import fsm_input_conditioner_pkg::*;

module fsm_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 16,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    fsm_input_conditioner_if.slave   io
);

    localparam int unsigned        TIMER_W     = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);

    logic               step_lvl_s;
    logic               dir_lvl_s;
    state_e             state_q;
    state_e             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               pulse_s;
    logic               step_pulse_q;
    logic               up_q;
    logic               repeat_active_q;

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_filter (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (io.btn_step_raw),
        .level_o (step_lvl_s)
    );

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dir_filter (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (io.sw_up_raw),
        .level_o (dir_lvl_s)
    );

    // FSM state and shared HOLD/REPEAT timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_RST;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state; release is checked first so it beats a same-cycle timer expiry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (step_lvl_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!step_lvl_s) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (REPEAT_EN == 1'b0) begin
                    timer_d = timer_q;
                end else if (timer_q >= HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            ST_REPEAT: begin
                if (!step_lvl_s) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q >= REPEAT_LAST) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Pulse request; the previous-pulse mask keeps strobes from ever abutting.
    always_comb begin
        pulse_s = 1'b0;
        case (state_q)
            ST_IDLE:   pulse_s = step_lvl_s;
            ST_HOLD:   pulse_s = step_lvl_s && REPEAT_EN && (timer_q >= HOLD_LAST);
            ST_REPEAT: pulse_s = step_lvl_s && (timer_q >= REPEAT_LAST);
            default:   pulse_s = 1'b0;
        endcase
        if (step_pulse_q) begin
            pulse_s = 1'b0;
        end else begin
            pulse_s = pulse_s;
        end
    end

    // Output registers; direction is frozen across the pulse cycle so the counter sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_pulse_q    <= PULSE_RST;
            up_q            <= UP_RST;
            repeat_active_q <= REPEAT_RST;
        end else begin
            step_pulse_q    <= pulse_s;
            repeat_active_q <= (state_d == ST_REPEAT);
            if (pulse_s) begin
                up_q <= up_q;
            end else begin
                up_q <= dir_lvl_s;
            end
        end
    end

    assign io.step_pulse    = step_pulse_q;
    assign io.up            = up_q;
    assign io.repeat_active = repeat_active_q;

endmodule
